reg_apb_initiator: RTL and testbench
====================================

REG_APB_INITIATOR -- requirements
Module: reg_apb_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 256, the maximum number of ACCESS cycles before abort (range 1..65535).
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  byte strobes
- req_prot  in  3  protection attributes
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response taken
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  abort caused by timeout
- p_addr  out  ADDR_W  APB address
- p_prot  out  3  APB protection
- p_sel  out  1  APB select
- p_enable  out  1  APB enable
- p_write  out  1  APB direction
- p_wdata  out  DATA_W  APB write data
- p_strb  out  DATA_W/8  APB strobes
- p_ready  in  1  APB ready
- p_rdata  in  DATA_W  APB read data
- p_slverr  in  1  APB error
REQ-005 SHALL use clk as the clock and rst_n as the reset (asynchronous, active-low).

Function
REQ-006 SHALL implement an FSM with the states IDLE, SETUP, ACCESS and RESP.
REQ-007 SHALL drive req_rdy high only in IDLE; a request is accepted on req_vld && req_rdy.
REQ-008 SHALL, on acceptance, latch write, addr, wdata, strb and prot into registers and go to SETUP.
REQ-009 SHALL, in SETUP, drive p_sel=1 and p_enable=0 for exactly one cycle, then go to ACCESS.
REQ-010 SHALL, in ACCESS, drive p_sel=1 and p_enable=1, and hold ACCESS while p_ready=0.
REQ-011 SHALL keep p_addr, p_write, p_wdata, p_strb and p_prot stable from SETUP through the last ACCESS cycle.
REQ-012 SHALL drive p_strb as all-zero for reads.
REQ-013 SHALL drive p_wdata as zero for reads.
REQ-014 SHALL, on an ACCESS cycle with p_ready=1, do all of the following:
- capture rsp_rdata = p_rdata for a read, or 0 for a write;
- set rsp_err = p_slverr and rsp_timeout = 0;
- go to RESP.
REQ-015 SHALL count ACCESS cycles with a 16-bit counter cleared on entry to SETUP.
REQ-016 SHALL abort when the counter reaches TIMEOUT with p_ready still 0:
- go to RESP;
- set rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-017 SHALL give p_ready=1 priority over timeout in the same cycle.
REQ-018 SHALL deassert p_sel and p_enable in IDLE and RESP; back-to-back APB transfers without an idle cycle are not supported.
REQ-019 SHALL hold rsp_vld=1 in RESP with the response fields stable until rsp_rdy=1, then go to IDLE.
REQ-020 SHALL register all outputs, with req_rdy a registered decode of the state.
REQ-021 SHALL provide zero-wait-state latency as follows:
- acceptance at cycle N;
- SETUP at N+1;
- ACCESS at N+2;
- rsp_vld at N+3;
- next acceptance no earlier than one cycle after the RESP handshake.
REQ-022 SHALL ignore p_ready and p_slverr outside ACCESS.
REQ-023 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE and clear the timeout counter.
REQ-025 SHALL, on rst_n low, immediately force req_rdy=0 and rsp_vld=0.
REQ-026 SHALL, on rst_n low, immediately force p_sel, p_enable, p_write, p_addr, p_wdata, p_strb, p_prot, rsp_rdata, rsp_err and rsp_timeout to 0.
REQ-027 SHALL assert req_rdy=1 on the first clock edge after rst_n deasserts.
REQ-028 SHALL, on reset during SETUP or ACCESS, drop the transfer with no response generated.

Structure
REQ-029 SHALL place in the shared package reg_apb_pkg:
- the FSM state enum;
- the default ADDR_W, DATA_W and TIMEOUT constants;
- the timeout counter width constant.
REQ-030 SHALL be a single module with the FSM, the latches and the counter inline; no sub-module.

Verification
REQ-031 SHALL cover a zero-wait read: addr 0x0004, slave returns p_ready=1 on the first ACCESS cycle with p_rdata 0xA5A5_0001 -> rsp_vld 3 cycles after acceptance, rsp_rdata 0xA5A5_0001, rsp_err 0, p_strb 0.
REQ-032 SHALL cover a write with strb 0b0101, wdata 0x1122_3344, 2 wait states -> p_wdata and p_strb stable for 3 ACCESS cycles, rsp_rdata 0, rsp_err 0.
REQ-033 SHALL cover a slave error: p_slverr=1 together with p_ready -> rsp_err 1, rsp_timeout 0.
REQ-034 SHALL cover timeout with TIMEOUT=4 and p_ready held 0 -> exactly 4 ACCESS cycles, then rsp_err 1, rsp_timeout 1, rsp_rdata 0, p_sel 0.
REQ-035 SHALL cover response backpressure: rsp_rdy held 0 for 5 cycles -> rsp_vld and the response fields stable, req_rdy 0, no new p_sel.
REQ-036 SHALL cover reset asserted during ACCESS -> all outputs 0 immediately, req_rdy 1 one cycle after release, no rsp_vld.

Source files
------------

// File: rtl/reg_apb_pkg.sv
// Shared types and defaults for the register-request to APB initiator.
// FSM encoding, default widths and the ACCESS watchdog counter width.
package reg_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 256;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/reg_apb_initiator.sv
// Single-outstanding request/response to APB initiator with ACCESS
// watchdog; every output is a flop, req_rdy tracks the next state.
module reg_apb_initiator
  import reg_apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [2:0]          req_prot,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   p_addr,
  output logic [2:0]          p_prot,
  output logic                p_sel,
  output logic                p_enable,
  output logic                p_write,
  output logic [DATA_W-1:0]   p_wdata,
  output logic [DATA_W/8-1:0] p_strb,
  input  logic                p_ready,
  input  logic [DATA_W-1:0]   p_rdata,
  input  logic                p_slverr
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_rdy     <= 1'b0;
      rsp_vld     <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      p_addr      <= '0;
      p_prot      <= '0;
      p_sel       <= 1'b0;
      p_enable    <= 1'b0;
      p_write     <= 1'b0;
      p_wdata     <= '0;
      p_strb      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          req_rdy <= 1'b1;
          if (req_vld && req_rdy) begin
            state    <= ST_SETUP;
            req_rdy  <= 1'b0;
            cnt      <= '0;
            p_sel    <= 1'b1;
            p_enable <= 1'b0;
            p_write  <= req_write;
            p_addr   <= req_addr;
            p_prot   <= req_prot;
            p_wdata  <= req_write ? req_wdata : '0;
            p_strb   <= req_write ? req_strb : '0;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          p_enable <= 1'b1;
        end
        ST_ACCESS: begin
          // ready wins over the watchdog when both land together
          if (p_ready) begin
            state       <= ST_RESP;
            p_sel       <= 1'b0;
            p_enable    <= 1'b0;
            rsp_vld     <= 1'b1;
            rsp_rdata   <= p_write ? '0 : p_rdata;
            rsp_err     <= p_slverr;
            rsp_timeout <= 1'b0;
          end else if (cnt_nxt >= TO_LIM) begin
            state       <= ST_RESP;
            p_sel       <= 1'b0;
            p_enable    <= 1'b0;
            rsp_vld     <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        ST_RESP: begin
          if (rsp_rdy) begin
            state   <= ST_IDLE;
            rsp_vld <= 1'b0;
            req_rdy <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          req_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_apb_initiator.sv
// Directed bench for reg_apb_initiator with a response scoreboard.
// Inputs driven and outputs sampled on the falling edge.
module tb_reg_apb_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] p_addr;
  logic [2:0]  p_prot;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic        p_ready = 1'b0;
  logic [31:0] p_rdata = '0;
  logic        p_slverr = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_apb_initiator #(
    .ADDR_W (16),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .req_prot   (req_prot),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .p_addr     (p_addr),
    .p_prot     (p_prot),
    .p_sel      (p_sel),
    .p_enable   (p_enable),
    .p_write    (p_write),
    .p_wdata    (p_wdata),
    .p_strb     (p_strb),
    .p_ready    (p_ready),
    .p_rdata    (p_rdata),
    .p_slverr   (p_slverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // acc: ACCESS cycles expected; rdy_last: slave answers on the last one
  task automatic xfer(input logic wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input int acc,
                      input logic rdy_last, input logic [31:0] rd,
                      input logic err, input int bp);
    rsp_t        e;
    rsp_t        got;
    logic [31:0] ewd;
    logic [3:0]  est;
    ewd = wr ? wd : 32'h0;
    est = wr ? st : 4'h0;
    if (!rdy_last) begin
      e.rdata = '0; e.err = 1'b1; e.to = 1'b1;
    end else begin
      e.rdata = wr ? 32'h0 : rd; e.err = err; e.to = 1'b0;
    end
    chk("accept_rdy", 64'(req_rdy), 64'd1);
    req_vld = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wd; req_strb = st; req_prot = pr;
    sb.push_back(e);
    @(negedge clk);
    req_vld = 1'b1; req_addr = ~addr; req_wdata = ~wd;
    chk("setup_sel_en", 64'({p_sel, p_enable, req_rdy}), 64'b100);
    chk("setup_addr", 64'({p_addr, p_prot, p_write}), 64'({addr, pr, wr}));
    chk("setup_wd_st", 64'({p_wdata, p_strb}), 64'({ewd, est}));
    for (int i = 0; i < acc; i++) begin
      @(negedge clk);
      req_vld = 1'b0;
      chk("acc_sel_en", 64'({p_sel, p_enable, rsp_vld}), 64'b110);
      chk("acc_addr", 64'({p_addr, p_prot, p_write}), 64'({addr, pr, wr}));
      chk("acc_wd_st", 64'({p_wdata, p_strb}), 64'({ewd, est}));
      p_ready  = (i == acc - 1) ? rdy_last : 1'b0;
      p_slverr = (i == acc - 1) ? err : 1'b1;
      p_rdata  = (i == acc - 1) ? rd : 32'hDEAD_BEEF;
    end
    @(negedge clk);
    p_ready = 1'b1; p_slverr = 1'b1; p_rdata = 32'hFFFF_FFFF;
    chk("resp_vld", 64'({rsp_vld, p_sel, p_enable, req_rdy}), 64'b1000);
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      got.rdata = rsp_rdata; got.err = rsp_err; got.to = rsp_timeout;
      e = sb.pop_front();
      chk("resp_fields", 64'({got.rdata, got.err, got.to}),
          64'({e.rdata, e.err, e.to}));
    end
    for (int i = 0; i < bp; i++) begin
      req_vld = 1'b1;
      @(negedge clk);
      chk("bp_hold", 64'({rsp_vld, req_rdy, p_sel, p_enable}), 64'b1000);
      chk("bp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}),
          64'({e.rdata, e.err, e.to}));
    end
    req_vld = 1'b0; p_ready = 1'b0; p_slverr = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("post_hs", 64'({rsp_vld, req_rdy, p_sel}), 64'b010);
  endtask

  initial begin
    #2;
    chk("rst_ctl", 64'({req_rdy, rsp_vld, p_sel, p_enable, p_write,
                        rsp_err, rsp_timeout}), 64'd0);
    chk("rst_data", 64'({p_addr, p_strb, p_prot}), 64'd0);
    chk("rst_wd_rd", 64'({p_wdata, rsp_rdata}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_rdy0", 64'(req_rdy), 64'd0);
    @(negedge clk);
    chk("rel_rdy1", 64'(req_rdy), 64'd1);

    xfer(1'b0, 16'h0004, 32'h0, 4'hF, 3'd0, 1, 1'b1,
         32'hA5A5_0001, 1'b0, 0);
    xfer(1'b1, 16'h0010, 32'h1122_3344, 4'b0101, 3'd2, 3, 1'b1,
         32'h5555_AAAA, 1'b0, 0);
    xfer(1'b0, 16'h0020, 32'h0, 4'h0, 3'd5, 1, 1'b1,
         32'h0BAD_0BAD, 1'b1, 0);
    xfer(1'b0, 16'h0030, 32'h0, 4'h0, 3'd1, 4, 1'b0,
         32'h1234_5678, 1'b0, 0);
    xfer(1'b1, 16'hFFFC, 32'hCAFE_F00D, 4'b1001, 3'd7, 4, 1'b1,
         32'h0, 1'b1, 0);
    xfer(1'b0, 16'h0040, 32'h0, 4'h0, 3'd3, 2, 1'b1,
         32'h600D_CAFE, 1'b0, 5);

    req_vld = 1'b1; req_write = 1'b1; req_addr = 16'h0050;
    req_wdata = 32'hFEED_FACE; req_strb = 4'hF; req_prot = 3'd6;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_acc", 64'({p_sel, p_enable}), 64'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({req_rdy, rsp_vld, p_sel, p_enable, p_write,
                            rsp_err, rsp_timeout}), 64'd0);
    chk("mid_rst_data", 64'({p_addr, p_strb, p_prot}), 64'd0);
    chk("mid_rst_wd", 64'({p_wdata, rsp_rdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 64'({req_rdy, rsp_vld, p_sel}), 64'b100);
    @(negedge clk);
    chk("no_rsp", 64'({req_rdy, rsp_vld, p_sel}), 64'b100);

    xfer(1'b0, 16'h0008, 32'h0, 4'h0, 3'd0, 1, 1'b1,
         32'h0000_0042, 1'b0, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
